fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
- Iterative IEEE-754 single-precision divider (q = a / b); the inverse operation of the combinational multiplier `mul_main`.
- Same operand format and the same overflow/underflow flag semantics as `mul_main`.
- Multi-cycle: start/done handshake, one quotient bit per cycle from a restoring mantissa divider.
- Sits beside `mul_main` in the FP arithmetic unit.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 supported.
- EXP_WIDTH, 8, exponent field width.
- MAN_WIDTH, 23, stored fraction width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  DATA_WIDTH  dividend; captured on accepted start.
- b  in  DATA_WIDTH  divisor; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse; result valid from this cycle on.
- q  out  DATA_WIDTH  quotient; held until the next accepted start.
- overflow  out  1  exponent overflow; q = signed infinity.
- underflow  out  1  exponent underflow; q = signed zero.
- div_by_zero  out  1  finite nonzero a divided by zero.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, q, overflow, underflow, div_by_zero all 0; internal registers cleared.
- Reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE -> SETUP -> DIVIDE -> NORM -> DONE -> IDLE.
- IDLE: start=1 captures a, b -> SETUP. start while not in IDLE is ignored (no queueing).
- Entering SETUP clears done and all flags (q is kept until DONE writes it).
- SETUP: unpack sign, exponent and fraction; sign = a[31]^b[31]. Inputs with exp==0 are flushed to zero (no denormal support). Special-case priority:
  1. Either operand NaN -> 32'h7FC00000.
  2. inf/inf or 0/0 -> 32'h7FC00000.
  3. inf/x -> signed infinity.
  4. x/0 -> signed infinity, div_by_zero=1.
  5. 0/x or x/inf -> signed zero.
  Any special case goes SETUP -> DONE directly.
  Normal operands: exp_tmp = ea - eb + 127 (10-bit signed); R = {1,ma}; D = {1,mb} -> DIVIDE.
- DIVIDE: restoring division, one iteration per cycle, NITER = 25 iterations.
  - Per cycle: if R >= D then qbit = 1 and R = R - D, else qbit = 0; then R = R << 1; the quotient register shifts left, taking in qbit.
  - A 5-bit counter terminates the loop.
- NORM:
  - If quo[24]=1: frac = quo[23:1], exp = exp_tmp.
  - Else: frac = quo[22:0], exp = exp_tmp - 1.
  - exp > 254 -> q = {sign, 8'hFF, 23'h0}, overflow=1.
  - exp < 1 -> q = {sign, 31'h0}, underflow=1.
  - Otherwise q = {sign, exp[7:0], frac}.
- DONE: done=1 for exactly one cycle; busy=0 in the same cycle; -> IDLE. A start in the cycle after DONE is accepted.
- Latency: counted from the start-sampling edge to the edge that raises done.
  - Normal path: 27 cycles (28 with the optional feature).
  - Special-case path: 2 cycles.
- Default rounding: truncation (round toward zero).

Optional Feature:
- Macro: FP_DIV_ROUND_NEAREST_EN.
- Defined:
  - NITER = 26, giving one guard bit.
  - sticky = (final R != 0).
  - Round to nearest, ties to even, applied in NORM.
  - A mantissa carry-out increments exp; overflow is checked after rounding.
- Undefined: NITER = 25, truncation; identical to the default behaviour.

Decomposition:
- Shared package fp_pkg:
  - Constants: EXP_WIDTH, MAN_WIDTH, BIAS=127, EXP_MAX=254, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - Typedef fp32_t (sign/exp/frac struct).
  - State enum div_state_t.
  - Classification functions is_nan, is_inf, is_zero; these are reusable by `mul_main`.
- Sub-module fp_div_mant_core:
  - Iterative restoring divider: load, R/D/quotient registers, iteration counter, finished flag, final remainder.
  - fp_div_seq keeps the FSM, special-case handling, normalization and rounding.

Test Plan:
- 6.0/2.0: a=32'h40C00000, b=32'h40000000 -> q=32'h40400000, all flags 0, done exactly 27 cycles after start, busy high in between.
- 1.0/3.0: a=32'h3F800000, b=32'h40400000 -> q=32'h3EAAAAAA by default; q=32'h3EAAAAAB with FP_DIV_ROUND_NEAREST_EN.
- Divide by zero: a=32'h3C2F0000, b=32'h00000000 -> q=32'h7F800000, div_by_zero=1, done 2 cycles after start. NaN case: a=32'h7F900000, b=32'h3F800000 -> q=32'h7FC00000.
- Overflow: a=32'h7F000000, b=32'h3E800000 -> q=32'h7F800000, overflow=1. Underflow: a=32'h00800000, b=32'h4F000000 -> q=32'h00000000, underflow=1.
- Handshake and reset:
  - start pulsed during DIVIDE with different operands -> ignored; first result unchanged.
  - rst_n low mid-DIVIDE -> all outputs 0 immediately, no done.
  - A new start after reset computes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision FP types, constants and classifiers for the FP arithmetic unit.
// FP_DIV_ROUND_NEAREST_EN selects the divider iteration count (guard bit for rounding).
package fp_pkg;

    localparam int unsigned EXP_WIDTH = 8;
    localparam int unsigned MAN_WIDTH = 23;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned EXP_MAX   = 254;
    localparam int unsigned CNT_WIDTH = 5;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

`ifdef FP_DIV_ROUND_NEAREST_EN
    localparam int unsigned NITER = 26;
`else
    localparam int unsigned NITER = 25;
`endif

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAN_WIDTH-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } div_state_t;

    // Denormals are flushed, so a zero exponent alone means zero.
    function automatic logic is_zero(input fp32_t x);
        return x.exp == '0;
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == '1) && (x.frac == '0);
    endfunction

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == '1) && (x.frac != '0);
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per clock after load.
// FP_DIV_ROUND_NEAREST_EN exposes the final-remainder-nonzero flag for sticky rounding.
module fp_div_mant_core
    import fp_pkg::*;
#(
    parameter int unsigned MW = MAN_WIDTH + 1,
    parameter int unsigned N  = NITER
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [MW-1:0] r_init,
    input  logic [MW-1:0] d_init,
    output logic [N-1:0]  quo,
`ifdef FP_DIV_ROUND_NEAREST_EN
    output logic          rem_nz,
`endif
    output logic          finish_c
);

    logic [MW:0]            rem;
    logic [MW-1:0]          div;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   active;
    logic                   qbit;
    logic [MW-1:0]          rem_sub;

    // Partial remainder stays below 2*D, so after a subtract it fits in MW bits.
    always_comb begin
        qbit    = rem >= {1'b0, div};
        rem_sub = qbit ? MW'(rem - {1'b0, div}) : rem[MW-1:0];
    end

    assign finish_c = active && (cnt == CNT_WIDTH'(N - 1));

`ifdef FP_DIV_ROUND_NEAREST_EN
    assign rem_nz = |rem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            div    <= '0;
            quo    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            rem    <= {1'b0, r_init};
            div    <= d_init;
            quo    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            rem <= {rem_sub, 1'b0};
            quo <= {quo[N-2:0], qbit};
            cnt <= cnt + CNT_WIDTH'(1);
            if (finish_c) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider q = a / b with start/done handshake.
// FP_DIV_ROUND_NEAREST_EN enables round-to-nearest-even (default: truncation).
module fp_div_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MAN_WIDTH  = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  div_by_zero
);
    import fp_pkg::*;

    localparam int unsigned EW  = EXP_WIDTH + 2;
    localparam int unsigned MW1 = MAN_WIDTH + 1;
    localparam logic signed [EW-1:0] EXP_HI = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] EXP_LO = EW'(1);

    div_state_t             state, state_d;
    logic                   busy_d, done_d, ovf_d, unf_d, dbz_d;
    logic [DATA_WIDTH-1:0]  q_d;
    fp32_t                  a_r, a_d, b_r, b_d;
    logic [DATA_WIDTH-1:0]  res, res_d;
    logic                   res_ovf, res_ovf_d, res_unf, res_unf_d, res_dbz, res_dbz_d;
    logic                   sign_r, sign_d;
    logic signed [EW-1:0]   exp_r, exp_d;

    logic [NITER-1:0]       quo;
    logic                   finish_c;
    logic                   load_c;

    logic                   quo_msb;
    logic [MAN_WIDTH-1:0]   frac_n;
    logic signed [EW-1:0]   exp_n;
    logic                   norm_ovf, norm_unf;
    logic [DATA_WIDTH-1:0]  norm_word;
`ifdef FP_DIV_ROUND_NEAREST_EN
    logic                   rem_nz, guard, sticky, carry;
`endif

    assign load_c = (state == S_IDLE) && start;

    fp_div_mant_core #(.MW(MW1), .N(NITER)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .r_init   ({1'b1, a[MAN_WIDTH-1:0]}),
        .d_init   ({1'b1, b[MAN_WIDTH-1:0]}),
        .quo      (quo),
`ifdef FP_DIV_ROUND_NEAREST_EN
        .rem_nz   (rem_nz),
`endif
        .finish_c (finish_c)
    );

    // Normalise the quotient (in [0.5, 2)) and pack, with range checks last.
    always_comb begin
        quo_msb = quo[NITER-1];
        frac_n  = quo_msb ? quo[NITER-2 -: MAN_WIDTH] : quo[NITER-3 -: MAN_WIDTH];
        exp_n   = quo_msb ? exp_r : exp_r - EW'(1);
`ifdef FP_DIV_ROUND_NEAREST_EN
        guard  = quo_msb ? quo[NITER-2-MAN_WIDTH] : quo[NITER-3-MAN_WIDTH];
        sticky = rem_nz | (quo_msb & quo[0]);
        carry  = 1'b0;
        if (guard && (sticky || frac_n[0])) begin
            {carry, frac_n} = {1'b0, frac_n} + MW1'(1);
        end
        if (carry) begin
            exp_n = exp_n + EW'(1);
        end
`endif
        norm_ovf = exp_n > EXP_HI;
        norm_unf = exp_n < EXP_LO;
        if (norm_ovf) begin
            norm_word = POS_INF | {sign_r, 31'h0};
        end else if (norm_unf) begin
            norm_word = {sign_r, 31'h0};
        end else begin
            norm_word = {sign_r, exp_n[EXP_WIDTH-1:0], frac_n};
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d   = state;
        busy_d    = busy;
        done_d    = 1'b0;
        q_d       = q;
        ovf_d     = overflow;
        unf_d     = underflow;
        dbz_d     = div_by_zero;
        a_d       = a_r;
        b_d       = b_r;
        res_d     = res;
        res_ovf_d = res_ovf;
        res_unf_d = res_unf;
        res_dbz_d = res_dbz;
        sign_d    = sign_r;
        exp_d     = exp_r;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    a_d     = fp32_t'(a);
                    b_d     = fp32_t'(b);
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                sign_d    = a_r.sign ^ b_r.sign;
                res_ovf_d = 1'b0;
                res_unf_d = 1'b0;
                res_dbz_d = 1'b0;
                state_d   = S_DONE;
                if (is_nan(a_r) || is_nan(b_r)) begin
                    res_d = QNAN;
                end else if ((is_inf(a_r) && is_inf(b_r)) || (is_zero(a_r) && is_zero(b_r))) begin
                    res_d = QNAN;
                end else if (is_inf(a_r)) begin
                    res_d = POS_INF | {sign_d, 31'h0};
                end else if (is_zero(b_r)) begin
                    res_d     = POS_INF | {sign_d, 31'h0};
                    res_dbz_d = 1'b1;
                end else if (is_zero(a_r) || is_inf(b_r)) begin
                    res_d = {sign_d, 31'h0};
                end else begin
                    exp_d   = EW'(a_r.exp) - EW'(b_r.exp) + EW'(BIAS);
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (finish_c) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                res_d     = norm_word;
                res_ovf_d = norm_ovf;
                res_unf_d = norm_unf;
                state_d   = S_DONE;
            end
            S_DONE: begin
                q_d     = res;
                ovf_d   = res_ovf;
                unf_d   = res_unf;
                dbz_d   = res_dbz;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            res         <= '0;
            res_ovf     <= 1'b0;
            res_unf     <= 1'b0;
            res_dbz     <= 1'b0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
        end else begin
            state       <= state_d;
            busy        <= busy_d;
            done        <= done_d;
            q           <= q_d;
            overflow    <= ovf_d;
            underflow   <= unf_d;
            div_by_zero <= dbz_d;
            a_r         <= a_d;
            b_r         <= b_d;
            res         <= res_d;
            res_ovf     <= res_ovf_d;
            res_unf     <= res_unf_d;
            res_dbz     <= res_dbz_d;
            sign_r      <= sign_d;
            exp_r       <= exp_d;
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: scoreboard of expected results popped on done.
module tb_fp_div_seq;

    typedef struct {
        logic [31:0] q;
        logic [2:0]  flags;   // {overflow, underflow, div_by_zero}
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

`ifdef FP_DIV_ROUND_NEAREST_EN
    localparam int          LAT_N = 28;
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam int          LAT_N = 27;
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif
    localparam int LAT_S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, overflow, underflow, div_by_zero;
    logic [31:0] q;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    // Drive one start pulse (caller sits just after a rising edge) and record the expectation.
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] eq, input logic [2:0] ef, input int el);
        exp_t e;
        e.q = eq; e.flags = ef; e.lat = el;
        sb.push_back(e);
        a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; reports latency and cycles where busy was unexpectedly low.
    task automatic wait_done(input int lat0, output int lat, output int busy_bad, output bit got);
        lat = lat0; busy_bad = 0; got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, q, overflow, underflow, div_by_zero} !== 37'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h flags=%b%b%b, need all zero",
                     busy, done, q, overflow, underflow, div_by_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_normal();
        vec_t v[$];
        exp_t e;
        int lat, bb; bit got;
        v.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, LAT_N}); // 6/2
        v.push_back('{32'h3F800000, 32'h40400000, THIRD,        3'b000, LAT_N}); // 1/3
        v.push_back('{32'hC0F00000, 32'h40200000, 32'hC0400000, 3'b000, LAT_N}); // -7.5/2.5
        v.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, LAT_N}); // 1/1
        v.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, LAT_N}); // exp 254 edge
        v.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, LAT_N}); // exp 1 edge
        v.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, LAT_N}); // overflow
        v.push_back('{32'h00800000, 32'h4F000000, 32'h00000000, 3'b010, LAT_N}); // underflow
        foreach (v[i]) begin
            issue(v[i].a, v[i].b, v[i].q, v[i].flags, v[i].lat);
            wait_done(0, lat, bb, got);
            e = sb.pop_front();
            checks++;
            if (got !== 1'b1) begin errors++; $display("FAIL normal[%0d] done: timed out after %0d cycles", i, lat); end
            checks++;
            if (q !== e.q) begin errors++; $display("FAIL normal[%0d] q: got %h need %h", i, q, e.q); end
            checks++;
            if ({overflow, underflow, div_by_zero} !== e.flags) begin
                errors++; $display("FAIL normal[%0d] flags: got %b%b%b need %b", i, overflow, underflow, div_by_zero, e.flags);
            end
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL normal[%0d] latency: got %0d need %0d", i, lat, e.lat); end
            checks++;
            if (bb !== 0 || busy !== 1'b0) begin
                errors++; $display("FAIL normal[%0d] busy: %0d low cycles, busy at done=%b, need 0 and 0", i, bb, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL normal[%0d] done_pulse: got %b need 0", i, done); end
        end
    endtask

    task automatic test_special();
        vec_t v[$];
        exp_t e;
        int lat, bb; bit got;
        v.push_back('{32'h3C2F0000, 32'h00000000, 32'h7F800000, 3'b001, LAT_S}); // x/0
        v.push_back('{32'h7F900000, 32'h3F800000, 32'h7FC00000, 3'b000, LAT_S}); // NaN/x
        v.push_back('{32'h00000000, 32'h7FC00001, 32'h7FC00000, 3'b000, LAT_S}); // 0/NaN
        v.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000, LAT_S}); // inf/inf
        v.push_back('{32'h00000000, 32'h80000000, 32'h7FC00000, 3'b000, LAT_S}); // 0/0
        v.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, LAT_S}); // -inf/2
        v.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 3'b000, LAT_S}); // -0/2
        v.push_back('{32'h40400000, 32'h7F800000, 32'h00000000, 3'b000, LAT_S}); // 3/inf
        v.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, LAT_S}); // denormal a
        v.push_back('{32'hBF800000, 32'h80000001, 32'h7F800000, 3'b001, LAT_S}); // -1/-denormal
        foreach (v[i]) begin
            issue(v[i].a, v[i].b, v[i].q, v[i].flags, v[i].lat);
            wait_done(0, lat, bb, got);
            e = sb.pop_front();
            checks++;
            if (got !== 1'b1) begin errors++; $display("FAIL special[%0d] done: timed out after %0d cycles", i, lat); end
            checks++;
            if (q !== e.q) begin errors++; $display("FAIL special[%0d] q: got %h need %h", i, q, e.q); end
            checks++;
            if ({overflow, underflow, div_by_zero} !== e.flags) begin
                errors++; $display("FAIL special[%0d] flags: got %b%b%b need %b", i, overflow, underflow, div_by_zero, e.flags);
            end
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL special[%0d] latency: got %0d need %0d", i, lat, e.lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int lat, bb, extra; bit got;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, LAT_N);
        repeat (5) begin @(posedge clk); #1; end
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6, lat, bb, got);
        e = sb.pop_front();
        checks++;
        if (got !== 1'b1 || q !== e.q) begin
            errors++; $display("FAIL ignore_start q: got %h (done seen=%b) need %h", q, got, e.q);
        end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL ignore_start latency: got %0d need %0d", lat, e.lat); end
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignore_start queued: got %0d extra done pulses need 0", extra); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat, bb; bit got;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, LAT_N);
        wait_done(0, lat, bb, got);
        e = sb.pop_front();
        checks++;
        if (got !== 1'b1 || q !== e.q) begin errors++; $display("FAIL b2b_first q: got %h need %h", q, e.q); end
        // Start in the done cycle itself; FSM is already back in idle.
        issue(32'h3C2F0000, 32'h00000000, 32'h7F800000, 3'b001, LAT_S);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got done=%b busy=%b need 0 1", done, busy);
        end
        wait_done(0, lat, bb, got);
        e = sb.pop_front();
        checks++;
        if (got !== 1'b1 || q !== e.q || {overflow, underflow, div_by_zero} !== e.flags) begin
            errors++; $display("FAIL b2b_second: got q=%h flags=%b%b%b need q=%h flags=%b",
                               q, overflow, underflow, div_by_zero, e.q, e.flags);
        end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL b2b_second latency: got %0d need %0d", lat, e.lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat, bb, seen; bit got;
        issue(32'hC0F00000, 32'h40200000, 32'hC0400000, 3'b000, LAT_N);
        repeat (10) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, q, overflow, underflow, div_by_zero} !== 37'h0) begin
            errors++; $display("FAIL reset_mid outputs: got busy=%b done=%b q=%h flags=%b%b%b need all zero",
                               busy, done, q, overflow, underflow, div_by_zero);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid no_done: got %0d done pulses need 0", seen); end
        issue(32'h3F800000, 32'h40400000, THIRD, 3'b000, LAT_N);
        wait_done(0, lat, bb, got);
        e = sb.pop_front();
        checks++;
        if (got !== 1'b1 || q !== e.q || {overflow, underflow, div_by_zero} !== e.flags) begin
            errors++; $display("FAIL reset_mid restart: got q=%h flags=%b%b%b need q=%h flags=%b",
                               q, overflow, underflow, div_by_zero, e.q, e.flags);
        end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL reset_mid restart latency: got %0d need %0d", lat, e.lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
